grey_sync_decoder: RTL and testbench
====================================

// Module: grey_sync_decoder
// PURPOSE
//  Consumer of 4-bit grey codes produced by the grey encoder stage, typically from an unrelated clock domain.
//  Synchronises the grey word into i_clk, converts it to binary, and reports unit steps (with direction) and illegal multi-bit jumps.
//  Sits between any grey-code source (grey encoder, FIFO pointer, absolute encoder) and binary consumers.
// PARAMETERS
//  WIDTH        4   grey/binary word width (>=2)
//  SYNC_STAGES  2   flops in the input synchroniser chain (>=2)
// PORTS
//  i_clk      in   1      single clock; all state on rising edge
//  i_rst_n    in   1      asynchronous active-low reset
//  i_grey     in   WIDTH  grey word, asynchronous to i_clk
//  i_en       in   1      block enable (synchronous)
//  i_err_clr  in   1      clears sticky o_err (synchronous)
//  o_bin      out  WIDTH  registered binary value of the synchronised grey word
//  o_valid    out  1      o_bin holds a decoded sample taken since the last enable/reset
//  o_step     out  1      one-cycle pulse: accepted sample differs from previous by exactly +/-1 (mod 2^WIDTH)
//  o_dir      out  1      direction of the last step: 1 = up, 0 = down; valid with/after o_step
//  o_err      out  1      sticky: a sample differed from the previous one in more than one bit
// BEHAVIOUR
//  Reset (async, i_rst_n=0): sync chain, o_bin, prev grey, o_valid, o_step, o_dir, o_err all 0; state IDLE. Takes effect immediately, mid-operation included.
//  Sync chain always shifts i_grey while out of reset (independent of i_en); sync output = stage SYNC_STAGES-1.
//  Decode: b[W-1]=g[W-1]; b[k]=b[k+1]^g[k]. Combinational on sync output; registered into o_bin.
//  FSM:
//   IDLE : o_valid=0, o_step=0. i_en=1 -> PRIME, prime count=0.
//   PRIME: count increments each cycle; at count==SYNC_STAGES-1 next edge loads baseline (o_bin, prev grey), o_valid<=1, -> RUN. No step/err on baseline.
//   RUN  : each edge compares sync output g with prev grey p:
//          popcount(g^p)==0 -> o_step=0, nothing changes.
//          ==1 -> o_bin/prev updated, o_step=1 for one cycle; o_dir=1 if new==old+1 mod 2^W else 0.
//          >1  -> o_bin/prev updated, o_step=0, o_err<=1.
//   Any state: i_en=0 -> IDLE next edge; o_valid<=0, o_step<=0, o_bin/o_dir/o_err hold.
//  Latency: i_grey change stable before edge N appears on o_bin after edge N+SYNC_STAGES (SYNC_STAGES+1 edges).
//  Wrap-around: max->0 (4'b1000 -> 4'b0000 grey at W=4) is an up step; 0->max is a down step.
//  o_err: set on illegal jump, cleared only by i_err_clr or reset; set and clear same cycle -> set wins. Preserved across i_en low.
//  Re-enable from IDLE always re-primes; the first sample never produces o_step or o_err.
// STRUCTURE
//  Package grey_pkg: function grey2bin(WIDTH), function popcount, FSM state enum {IDLE, PRIME, RUN}.
//  Sub-module grey_sync_chain (SYNC_STAGES x WIDTH flops, async-reset-low); decode, compare and FSM live in the top.
// TESTING
//  Reset then i_en=1, i_grey=4'b0110 held -> o_valid rises 3 edges after enable (SYNC_STAGES=2), o_bin=4'd4, no o_step, o_err=0.
//  Count up 0..15..0 in grey, one code per 4 clocks -> 16 o_step pulses, o_dir=1 each, wrap 15->0 counted as up, o_err=0.
//  Count down 3,2,1,0,15 -> 4 o_step pulses with o_dir=0, o_bin ends at 4'd15.
//  Jump grey 4'b0000 -> 4'b0011 (bin 0->2) -> o_bin=2, no o_step, o_err=1; i_err_clr pulse coinciding with a second illegal jump -> o_err stays 1; later lone clear -> 0.
//  i_en low 5 cycles while i_grey changes, then high -> o_valid 0 during off, re-prime, new baseline loaded with no step/err.
//  Assert i_rst_n=0 mid-count between clock edges -> all outputs 0 immediately, state IDLE; release -> behaves as fresh reset.

Source files
------------

// File: rtl/grey_pkg.sv
// Shared types and helpers for the grey-code synchroniser/decoder.
// grey2bin and popcount work on a MAX_W-wide zero-extended word, so any
// WIDTH up to MAX_W is served by casting in and truncating out.
package grey_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned POP_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Grey to binary: b[k] = b[k+1] ^ g[k]; zero upper bits leave the low bits unaffected.
    function automatic logic [MAX_W-1:0] grey2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int k = int'(MAX_W) - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Number of set bits.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/grey_sync_chain.sv
// Multi-flop synchroniser for a grey-coded word crossing into i_clk.
// Ports: i_clk, i_rst_n (async active-low), i_grey (async word),
//        o_sync (word after SYNC_STAGES flops).
module grey_sync_chain #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_grey,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    // Shift path: stage 0 samples the input, each later stage takes the one before.
    always_comb begin
        sync_d[0] = i_grey;
        for (int k = 1; k < int'(SYNC_STAGES); k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/grey_sync_decoder.sv
// Synchronises a grey word into i_clk, decodes it to binary and classifies
// each change as a unit step (with direction) or an illegal multi-bit jump.
// Ports: i_clk, i_rst_n (async active-low), i_grey (async grey word),
//        i_en (enable), i_err_clr (clear sticky error),
//        o_bin (decoded value), o_valid (baseline loaded), o_step (unit-step pulse),
//        o_dir (1 = up), o_err (sticky illegal-jump flag).
module grey_sync_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_grey,
    input  logic             i_en,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_valid,
    output logic             o_step,
    output logic             o_dir,
    output logic             o_err
);
    import grey_pkg::*;

    localparam int unsigned CNT_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;

    logic [WIDTH-1:0] sync_g;
    logic [WIDTH-1:0] dec_bin;
    logic [POP_W-1:0] diff_bits;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    grey_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_grey  (i_grey),
        .o_sync  (sync_g)
    );

    // Decode and compare against the last accepted grey word.
    assign dec_bin   = WIDTH'(grey2bin(MAX_W'(sync_g)));
    assign diff_bits = popcount(MAX_W'(sync_g ^ prev_q));

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = err_q;

        // Clear first so a same-cycle set below takes priority.
        if (i_err_clr) begin
            err_d = 1'b0;
        end

        if (!i_en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
                // Wait for the chain to flush pre-enable samples, then take a baseline.
                PRIME: begin
                    if (cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
                        bin_d   = dec_bin;
                        prev_d  = sync_g;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (diff_bits == POP_W'(1)) begin
                        bin_d  = dec_bin;
                        prev_d = sync_g;
                        step_d = 1'b1;
                        dir_d  = (dec_bin == WIDTH'(bin_q + WIDTH'(1)));
                    end else if (diff_bits > POP_W'(1)) begin
                        bin_d  = dec_bin;
                        prev_d = sync_g;
                        err_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign o_bin   = bin_q;
    assign o_valid = valid_q;
    assign o_step  = step_q;
    assign o_dir   = dir_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_grey_sync_decoder.sv
// Directed self-checking bench for grey_sync_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_grey_sync_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] grey;
    logic       en;
    logic       err_clr;
    logic [3:0] bin;
    logic       valid;
    logic       step;
    logic       dir;
    logic       err;

    int checks;
    int errors;
    int step_cnt;
    int up_cnt;
    int err_seen;

    grey_sync_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_grey    (grey),
        .i_en      (en),
        .i_err_clr (err_clr),
        .o_bin     (bin),
        .o_valid   (valid),
        .o_step    (step),
        .o_dir     (dir),
        .o_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_grey(input int n);
        logic [3:0] v;
        v = 4'(n);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, tallying step pulses seen at each one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (step === 1'b1) begin
                step_cnt++;
                if (dir === 1'b1) up_cnt++;
            end
        end
    endtask

    task automatic clr_tally();
        step_cnt = 0;
        up_cnt   = 0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        step_cnt = 0;
        up_cnt   = 0;
        err_seen = 0;
        rst_n    = 1'b0;
        grey     = 4'b0000;
        en       = 1'b0;
        err_clr  = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Baseline: grey 0110 -> bin 4, valid on the third edge after enable
        grey = 4'b0110;
        cyc(3);
        en = 1'b1;
        clr_tally();
        cyc(2);
        chk("prime_valid_lo", 32'(valid), 32'd0);
        cyc(1);
        chk("prime_valid_hi", 32'(valid), 32'd1);
        chk("prime_bin", 32'(bin), 32'd4);
        chk("prime_step", 32'(step_cnt), 32'd0);
        chk("prime_err", 32'(err), 32'd0);

        // Re-prime at 0 without a step
        en = 1'b0;
        grey = 4'b0000;
        cyc(4);
        chk("off_valid", 32'(valid), 32'd0);
        chk("off_bin_hold", 32'(bin), 32'd4);
        en = 1'b1;
        clr_tally();
        cyc(4);
        chk("reprime_bin", 32'(bin), 32'd0);
        chk("reprime_nostep", 32'(step_cnt), 32'd0);

        // Count up 1..15,0: 16 up steps including the wrap
        clr_tally();
        for (int i = 1; i <= 16; i++) begin
            grey = to_grey(i % 16);
            cyc(4);
        end
        chk("up_steps", 32'(step_cnt), 32'd16);
        chk("up_dirs", 32'(up_cnt), 32'd16);
        chk("up_bin", 32'(bin), 32'd0);
        chk("up_err", 32'(err), 32'd0);

        // Walk up to 3, then count down 2,1,0,15
        for (int i = 1; i <= 3; i++) begin
            grey = to_grey(i);
            cyc(4);
        end
        chk("pre_down_bin", 32'(bin), 32'd3);
        clr_tally();
        grey = to_grey(2); cyc(4);
        grey = to_grey(1); cyc(4);
        grey = to_grey(0); cyc(4);
        grey = to_grey(15); cyc(4);
        chk("down_steps", 32'(step_cnt), 32'd4);
        chk("down_dirs_up", 32'(up_cnt), 32'd0);
        chk("down_dir", 32'(dir), 32'd0);
        chk("down_bin", 32'(bin), 32'd15);
        chk("down_err", 32'(err), 32'd0);

        // 15 -> 0 up, then illegal grey 0000 -> 0011 (bin 0 -> 2)
        grey = 4'b0000; cyc(4);
        chk("wrap_dir", 32'(dir), 32'd1);
        clr_tally();
        grey = 4'b0011; cyc(4);
        chk("jump_bin", 32'(bin), 32'd2);
        chk("jump_nostep", 32'(step_cnt), 32'd0);
        chk("jump_err", 32'(err), 32'd1);

        // Second illegal jump (0011 -> 1100, bin 8) with a coincident clear
        grey = 4'b1100;
        cyc(2);
        chk("latency_hold", 32'(bin), 32'd2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("latency_bin", 32'(bin), 32'd8);
        chk("setclr_err", 32'(err), 32'd1);
        cyc(2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("lone_clr_err", 32'(err), 32'd0);

        // Illegal jump 1100 -> 1111 (bin 10), then enable low 5 cycles
        grey = 4'b1111; cyc(4);
        chk("jump2_bin", 32'(bin), 32'd10);
        chk("jump2_err", 32'(err), 32'd1);
        en = 1'b0;
        clr_tally();
        for (int i = 0; i < 5; i++) begin
            grey = to_grey(i * 3 + 1);
            cyc(1);
            if (valid !== 1'b0) err_seen++;
        end
        chk("en_off_valid", 32'(err_seen), 32'd0);
        chk("en_off_bin", 32'(bin), 32'd10);
        chk("en_off_err", 32'(err), 32'd1);
        chk("en_off_step", 32'(step_cnt), 32'd0);
        grey = 4'b0101;
        en = 1'b1;
        cyc(2);
        chk("en_on_valid_lo", 32'(valid), 32'd0);
        cyc(1);
        chk("en_on_valid_hi", 32'(valid), 32'd1);
        chk("en_on_bin", 32'(bin), 32'd6);
        chk("en_on_step", 32'(step_cnt), 32'd0);
        chk("en_on_err", 32'(err), 32'd1);

        // Step 6 -> 7, then reset between edges mid-count
        grey = to_grey(7); cyc(4);
        chk("pre_rst_bin", 32'(bin), 32'd7);
        chk("pre_rst_dir", 32'(dir), 32'd1);
        grey = to_grey(8);
        cyc(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bin", 32'(bin), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_step", 32'(step), 32'd0);
        chk("async_dir", 32'(dir), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        clr_tally();
        cyc(2);
        chk("rerst_valid_lo", 32'(valid), 32'd0);
        cyc(1);
        chk("rerst_valid_hi", 32'(valid), 32'd1);
        chk("rerst_bin", 32'(bin), 32'd8);
        chk("rerst_step", 32'(step_cnt), 32'd0);
        chk("rerst_err", 32'(err), 32'd0);
        grey = to_grey(9); cyc(4);
        chk("post_rst_step", 32'(step_cnt), 32'd1);
        chk("post_rst_up", 32'(up_cnt), 32'd1);
        chk("post_rst_bin", 32'(bin), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
